bottling_ctrl: RTL and testbench
================================

# bottling_ctrl

Parametrised pill-bottling control core: counts pills per bottle and bottles per batch in BCD and sequences the fill/switch/fault states. Generalises the fixed 3-digit/2-digit bottling state machine to configurable digit counts and timeouts. Adds target latching, spill detection during bottle switching, error-cause reporting and an ERROR-to-FATAL escalation timeout. Sits between the button/switch front end and the seven-segment/beeper display logic.

## Interface
- PILL_DIGITS, 3, BCD digits of pill count/target
- BOTTLE_DIGITS, 2, BCD digits of bottle count/target
- TICK_DIV, 1000, clk_1khz cycles per one-second timer tick (≥2)
- SWITCH_SEC, 2, bottle-switch dwell in seconds (≥1)
- HOPPER_SEC, 5, max seconds between pills before hopper fault (≥1)
- ERROR_SEC, 10, max seconds in ERROR before escalation to FATAL (≥1)

- clk_1khz  in  1  sole clock, all logic on rising edge
- switch_clr  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; begins batch from SETTING
- ack  in  1  one-cycle pulse; leaves DONE/FATAL
- estop  in  1  emergency stop, level
- pill_in  in  1  raw hopper level; each rising edge is one pill
- conveyor_ok  in  1  conveyor running, level
- target_pills  in  4*PILL_DIGITS  BCD pills per bottle, digit 0 in [3:0]
- target_bottles  in  4*BOTTLE_DIGITS  BCD bottles per batch
- state  out  3  0 SETTING, 1 RUNNING, 2 SWITCHING, 3 DONE, 4 ERROR, 5 FATAL
- now_pills  out  4*PILL_DIGITS  BCD pills in current bottle
- now_bottles  out  4*BOTTLE_DIGITS  BCD completed bottles
- err_cause  out  2  0 none, 1 hopper, 2 conveyor, 3 spill/estop
- bottle_done  out  1  one-cycle pulse per completed bottle
- chime  out  1  one-cycle pulse on first cycle of RUNNING

## Operation
- Reset: state SETTING, counters 0, err_cause 0, pulses 0, timers 0, prescaler 0, pill edge register 1 (level high at release is not a pill).
- Pill edge = pill_in & ~pill_prev, registered prev.
- estop high: any state → FATAL, err_cause 3; overrides all else. ack in FATAL ignored while estop high.
- SETTING: start with both targets nonzero → latch targets, clear counters, err_cause 0, RUNNING. start with a zero target ignored. Later target changes have no effect until next start.
- RUNNING: pill edge increments now_pills (BCD ripple, 9→0 carry) and reloads hopper timer. If incremented value equals latched target: now_bottles increments, bottle_done pulses, then DONE if new now_bottles equals target, else SWITCHING. Hopper timer expiry with no pill → ERROR, cause 1. Pill edge and expiry in the same cycle: pill wins.
- SWITCHING: timer loaded with SWITCH_SEC. Pill edge → FATAL, cause 3. Expiry: conveyor_ok → clear now_pills, RUNNING; else ERROR, cause 2.
- ERROR cause 1: pill edge → RUNNING, pill counted with full RUNNING completion rules. ERROR cause 2: conveyor_ok → clear now_pills, RUNNING. ERROR timer (ERROR_SEC) expiry → FATAL, err_cause unchanged.
- DONE / FATAL: ack → SETTING; counters and err_cause hold until next start.
- Pill edges in SETTING, DONE, FATAL ignored.

## Timing
- All outputs registered; a transition is visible the cycle after the triggering input is sampled.
- bottle_done asserts in the same cycle as the now_bottles update.
- Prescaler restarts at 0 on every state change and on every hopper reload. An N-second timer therefore expires exactly N*TICK_DIV cycles after its load cycle.
- Hopper timer loads on RUNNING entry and on each counted pill.
- No counter overflow: now_pills never exceeds target; now_bottles never exceeds target.

## Structure
- Package bottling_pkg: state encodings, err_cause codes, digit-width helper.
- Sub-module bcd_counter #(DIGITS): ports clr, inc, q, eq(target). Instanced twice (pills, bottles).
- Timer widths via $clog2 of the largest second count and of TICK_DIV.

## Test plan
(TICK_DIV=4, SWITCH_SEC=2, HOPPER_SEC=5, ERROR_SEC=3)
- Targets 003/02, start, 6 pill edges with conveyor_ok=1 → two bottle_done pulses; SWITCHING lasts 8 cycles; then DONE, now_bottles=02; ack → SETTING.
- Target 012 pills: 12 edges → now_pills steps …009→010→011→012, correct carry, no 00A code.
- No pills for 20 cycles in RUNNING → ERROR cause 1. Pill edge → RUNNING, now_pills incremented. Stay 12 cycles in ERROR → FATAL.
- Pill edge during SWITCHING → FATAL cause 3. conveyor_ok=0 at switch expiry → ERROR cause 2; conveyor_ok=1 → RUNNING, now_pills=000, chime pulse.
- estop mid-RUNNING → FATAL next cycle; ack with estop high ignored; estop low then ack → SETTING. start with target_pills=000 ignored.
- switch_clr pulsed asynchronously mid-SWITCHING → all outputs at reset values immediately.

Source files
------------

// File: rtl/bottling_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bottling_pkg
// Purpose  : State and error-cause encodings shared by the bottling control core
// Revision : 1.0
// ============================================================================
package bottling_pkg;

    typedef enum logic [2:0] {
        ST_SETTING   = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_SWITCHING = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4,
        ST_FATAL     = 3'd5
    } state_t;

    localparam logic [1:0] c_ERR_NONE     = 2'd0;
    localparam logic [1:0] c_ERR_HOPPER   = 2'd1;
    localparam logic [1:0] c_ERR_CONVEYOR = 2'd2;
    localparam logic [1:0] c_ERR_SPILL    = 2'd3;

    function automatic int unsigned bcd_width(input int unsigned digits);
        return 4 * digits;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bottling_ctrl_bcd_counter.sv
`default_nettype none
// ============================================================================
// Module   : bcd_counter
// Purpose  : Multi-digit BCD up-counter; eq flags that the next count hits target
// Revision : 1.0
// ============================================================================
module bcd_counter
    import bottling_pkg::*;
#(
    parameter int DIGITS = 3
) (
    input  logic                           clk_1khz,
    input  logic                           switch_clr,
    input  logic                           clr,
    input  logic                           inc,
    input  logic [bcd_width(DIGITS)-1:0]   target,
    output logic [bcd_width(DIGITS)-1:0]   q,
    output logic                           eq
);

    logic [bcd_width(DIGITS)-1:0] r_q;
    logic [bcd_width(DIGITS)-1:0] w_q_inc;
    logic [DIGITS-1:0]            w_carry;

    assign w_carry[0] = 1'b1;

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        logic [3:0] w_d;
        assign w_d = r_q[4*i +: 4];
        assign w_q_inc[4*i +: 4] = !w_carry[i]     ? w_d  :
                                   (w_d == 4'd9)   ? 4'd0 : w_d + 4'd1;
        if (i < DIGITS - 1) begin : g_ripple
            assign w_carry[i+1] = w_carry[i] & (w_d == 4'd9);
        end
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc) begin
            r_q <= w_q_inc;
        end
    end

    assign q  = r_q;
    // Look-ahead compare lets the caller act on completion in the counting cycle.
    assign eq = (w_q_inc == target);

endmodule
`default_nettype wire

// File: rtl/bottling_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bottling_ctrl
// Purpose  : Pill/bottle BCD counting and fill/switch/fault sequencing
// Revision : 1.0
// ============================================================================
module bottling_ctrl
    import bottling_pkg::*;
#(
    parameter int PILL_DIGITS   = 3,
    parameter int BOTTLE_DIGITS = 2,
    parameter int TICK_DIV      = 1000,
    parameter int SWITCH_SEC    = 2,
    parameter int HOPPER_SEC    = 5,
    parameter int ERROR_SEC     = 10
) (
    input  logic                                 clk_1khz,
    input  logic                                 switch_clr,
    input  logic                                 start,
    input  logic                                 ack,
    input  logic                                 estop,
    input  logic                                 pill_in,
    input  logic                                 conveyor_ok,
    input  logic [bcd_width(PILL_DIGITS)-1:0]    target_pills,
    input  logic [bcd_width(BOTTLE_DIGITS)-1:0]  target_bottles,
    output logic [2:0]                           state,
    output logic [bcd_width(PILL_DIGITS)-1:0]    now_pills,
    output logic [bcd_width(BOTTLE_DIGITS)-1:0]  now_bottles,
    output logic [1:0]                           err_cause,
    output logic                                 bottle_done,
    output logic                                 chime
);

    localparam int c_MAX_SW_HOP = (SWITCH_SEC > HOPPER_SEC) ? SWITCH_SEC : HOPPER_SEC;
    localparam int c_MAX_SEC    = (c_MAX_SW_HOP > ERROR_SEC) ? c_MAX_SW_HOP : ERROR_SEC;
    localparam int c_SEC_W      = $clog2(c_MAX_SEC + 1);
    localparam int c_PRE_W      = $clog2(TICK_DIV);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);

    state_t                              r_state;
    logic [1:0]                          r_cause;
    logic                                r_done;
    logic                                r_chime;
    logic                                r_pill_prev;
    logic [bcd_width(PILL_DIGITS)-1:0]   r_tgt_pills;
    logic [bcd_width(BOTTLE_DIGITS)-1:0] r_tgt_bottles;
    logic [c_SEC_W-1:0]                  r_sec;
    logic [c_PRE_W-1:0]                  r_pre;

    state_t             w_next;
    logic [1:0]         w_next_cause;
    logic [c_SEC_W-1:0] w_load_sec;
    logic               w_pill_edge;
    logic               w_expire;
    logic               w_count;
    logic               w_pill_inc;
    logic               w_pill_clr;
    logic               w_pill_eq;
    logic               w_bot_inc;
    logic               w_bot_clr;
    logic               w_bot_eq;
    logic               w_latch;
    logic               w_reload;
    logic               w_done;

    assign w_pill_edge = pill_in & ~r_pill_prev;
    assign w_expire    = (r_sec == c_SEC_W'(1)) && (r_pre == c_PRE_LAST);

    always_comb begin
        w_next       = r_state;
        w_next_cause = r_cause;
        w_count      = 1'b0;
        w_pill_inc   = 1'b0;
        w_pill_clr   = 1'b0;
        w_bot_inc    = 1'b0;
        w_bot_clr    = 1'b0;
        w_latch      = 1'b0;
        w_reload     = 1'b0;
        w_done       = 1'b0;
        w_load_sec   = '0;

        if (estop) begin
            w_next       = ST_FATAL;
            w_next_cause = c_ERR_SPILL;
        end else begin
            case (r_state)
                ST_SETTING: begin
                    if (start && (|target_pills) && (|target_bottles)) begin
                        w_latch      = 1'b1;
                        w_pill_clr   = 1'b1;
                        w_bot_clr    = 1'b1;
                        w_next_cause = c_ERR_NONE;
                        w_next       = ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (w_pill_edge) begin
                        w_count = 1'b1;
                    end else if (w_expire) begin
                        w_next       = ST_ERROR;
                        w_next_cause = c_ERR_HOPPER;
                    end
                end
                ST_SWITCHING: begin
                    if (w_pill_edge) begin
                        w_next       = ST_FATAL;
                        w_next_cause = c_ERR_SPILL;
                    end else if (w_expire) begin
                        if (conveyor_ok) begin
                            w_pill_clr = 1'b1;
                            w_next     = ST_RUNNING;
                        end else begin
                            w_next       = ST_ERROR;
                            w_next_cause = c_ERR_CONVEYOR;
                        end
                    end
                end
                ST_ERROR: begin
                    // Recovery takes priority over escalation when both land together.
                    if ((r_cause == c_ERR_HOPPER) && w_pill_edge) begin
                        w_count = 1'b1;
                    end else if ((r_cause == c_ERR_CONVEYOR) && conveyor_ok) begin
                        w_pill_clr = 1'b1;
                        w_next     = ST_RUNNING;
                    end else if (w_expire) begin
                        w_next = ST_FATAL;
                    end
                end
                ST_DONE, ST_FATAL: begin
                    if (ack) begin
                        w_next = ST_SETTING;
                    end
                end
                default: w_next = ST_SETTING;
            endcase
        end

        if (w_count) begin
            w_pill_inc = 1'b1;
            w_reload   = 1'b1;
            w_next     = ST_RUNNING;
            if (w_pill_eq) begin
                w_bot_inc = 1'b1;
                w_done    = 1'b1;
                w_next    = w_bot_eq ? ST_DONE : ST_SWITCHING;
            end
        end

        case (w_next)
            ST_RUNNING:   w_load_sec = c_SEC_W'(HOPPER_SEC);
            ST_SWITCHING: w_load_sec = c_SEC_W'(SWITCH_SEC);
            ST_ERROR:     w_load_sec = c_SEC_W'(ERROR_SEC);
            default:      w_load_sec = '0;
        endcase
    end

    always_ff @(posedge clk_1khz or posedge switch_clr) begin
        if (switch_clr) begin
            r_state       <= ST_SETTING;
            r_cause       <= c_ERR_NONE;
            r_done        <= 1'b0;
            r_chime       <= 1'b0;
            r_pill_prev   <= 1'b1;
            r_tgt_pills   <= '0;
            r_tgt_bottles <= '0;
            r_sec         <= '0;
            r_pre         <= '0;
        end else begin
            r_state     <= w_next;
            r_cause     <= w_next_cause;
            r_done      <= w_done;
            r_chime     <= (w_next == ST_RUNNING) && (r_state != ST_RUNNING);
            r_pill_prev <= pill_in;
            if (w_latch) begin
                r_tgt_pills   <= target_pills;
                r_tgt_bottles <= target_bottles;
            end
            // Seconds timer: reload on any state change or counted pill.
            if ((w_next != r_state) || w_reload) begin
                r_pre <= '0;
                r_sec <= w_load_sec;
            end else if (r_pre == c_PRE_LAST) begin
                r_pre <= '0;
                if (r_sec != '0) begin
                    r_sec <= r_sec - 1'b1;
                end
            end else begin
                r_pre <= r_pre + 1'b1;
            end
        end
    end

    bcd_counter #(.DIGITS(PILL_DIGITS)) u_pills (
        .clk_1khz   (clk_1khz),
        .switch_clr (switch_clr),
        .clr        (w_pill_clr),
        .inc        (w_pill_inc),
        .target     (r_tgt_pills),
        .q          (now_pills),
        .eq         (w_pill_eq)
    );

    bcd_counter #(.DIGITS(BOTTLE_DIGITS)) u_bottles (
        .clk_1khz   (clk_1khz),
        .switch_clr (switch_clr),
        .clr        (w_bot_clr),
        .inc        (w_bot_inc),
        .target     (r_tgt_bottles),
        .q          (now_bottles),
        .eq         (w_bot_eq)
    );

    assign state       = r_state;
    assign err_cause   = r_cause;
    assign bottle_done = r_done;
    assign chime       = r_chime;

endmodule
`default_nettype wire

// File: tb/tb_bottling_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_bottling_ctrl
// Purpose  : Self-checking bench for bottling_ctrl against an integer-level model
// Revision : 1.0
// ============================================================================
module tb_bottling_ctrl;

    localparam int c_TICK = 4;
    localparam int c_SW   = 2;
    localparam int c_HOP  = 5;
    localparam int c_ERR  = 3;

    logic        clk_1khz = 1'b0;
    logic        switch_clr, start, ack, estop, pill_in, conveyor_ok;
    logic [11:0] target_pills;
    logic [7:0]  target_bottles;
    logic [2:0]  state;
    logic [11:0] now_pills;
    logic [7:0]  now_bottles;
    logic [1:0]  err_cause;
    logic        bottle_done, chime;

    int n_chk = 0;
    int n_err = 0;
    int sw_samples = 0;
    int done_samples = 0;

    // Reference model: plain integers, cycle-count deadlines
    int m_state, m_pills, m_bottles, m_cause, m_tp, m_tb, m_left;
    bit m_done, m_chime, m_prev;

    always #5 clk_1khz = ~clk_1khz;

    bottling_ctrl #(
        .PILL_DIGITS   (3),
        .BOTTLE_DIGITS (2),
        .TICK_DIV      (c_TICK),
        .SWITCH_SEC    (c_SW),
        .HOPPER_SEC    (c_HOP),
        .ERROR_SEC     (c_ERR)
    ) dut (
        .clk_1khz       (clk_1khz),
        .switch_clr     (switch_clr),
        .start          (start),
        .ack            (ack),
        .estop          (estop),
        .pill_in        (pill_in),
        .conveyor_ok    (conveyor_ok),
        .target_pills   (target_pills),
        .target_bottles (target_bottles),
        .state          (state),
        .now_pills      (now_pills),
        .now_bottles    (now_bottles),
        .err_cause      (err_cause),
        .bottle_done    (bottle_done),
        .chime          (chime)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    function automatic int bcd2int(input logic [31:0] b, input int digits);
        int v = 0;
        for (int i = digits - 1; i >= 0; i--) v = v * 10 + int'(b[4*i +: 4]);
        return v;
    endfunction

    function automatic logic [31:0] int2bcd(input int v);
        logic [31:0] r = '0;
        int x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int sec_of(input int st);
        case (st)
            1:       return c_HOP;
            2:       return c_SW;
            4:       return c_ERR;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        m_state = 0; m_pills = 0; m_bottles = 0; m_cause = 0;
        m_tp = 0; m_tb = 0; m_left = 0;
        m_done = 0; m_chime = 0; m_prev = 1;
    endtask

    task automatic model_step();
        bit edge_s, expired, count;
        int ns;
        edge_s  = pill_in && !m_prev;
        m_prev  = pill_in;
        expired = 0;
        if (m_left > 0) begin
            m_left--;
            expired = (m_left == 0);
        end
        ns = m_state; m_done = 0; count = 0;
        if (estop) begin
            ns = 5; m_cause = 3;
        end else begin
            case (m_state)
                0: if (start && target_pills != 0 && target_bottles != 0) begin
                       m_tp = bcd2int(32'(target_pills), 3);
                       m_tb = bcd2int(32'(target_bottles), 2);
                       m_pills = 0; m_bottles = 0; m_cause = 0; ns = 1;
                   end
                1: if (edge_s) count = 1;
                   else if (expired) begin ns = 4; m_cause = 1; end
                2: if (edge_s) begin ns = 5; m_cause = 3; end
                   else if (expired) begin
                       if (conveyor_ok) begin m_pills = 0; ns = 1; end
                       else begin ns = 4; m_cause = 2; end
                   end
                4: if (m_cause == 1 && edge_s) count = 1;
                   else if (m_cause == 2 && conveyor_ok) begin m_pills = 0; ns = 1; end
                   else if (expired) ns = 5;
                3, 5: if (ack) ns = 0;
                default: ns = 0;
            endcase
        end
        if (count) begin
            m_pills++;
            ns = 1;
            if (m_pills == m_tp) begin
                m_bottles++;
                m_done = 1;
                ns = (m_bottles == m_tb) ? 3 : 2;
            end
        end
        m_chime = (ns == 1) && (m_state != 1);
        if (ns != m_state || count) m_left = sec_of(ns) * c_TICK;
        m_state = ns;
    endtask

    task automatic compare_all();
        check_eq("state",       32'(state),       m_state);
        check_eq("now_pills",   32'(now_pills),   int2bcd(m_pills));
        check_eq("now_bottles", 32'(now_bottles), int2bcd(m_bottles));
        check_eq("err_cause",   32'(err_cause),   m_cause);
        check_eq("bottle_done", 32'(bottle_done), 32'(m_done));
        check_eq("chime",       32'(chime),       32'(m_chime));
        if (state == 3'd2) sw_samples++;
        if (bottle_done)   done_samples++;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_1khz);
        #1;
        compare_all();
        start = 1'b0;
        ack   = 1'b0;
    endtask

    task automatic pill();
        pill_in = 1'b1; tick();
        pill_in = 1'b0; tick();
    endtask

    initial begin
        logic [31:0] tmp;
        switch_clr = 1'b1; start = 1'b0; ack = 1'b0; estop = 1'b0;
        pill_in = 1'b0; conveyor_ok = 1'b1; target_pills = '0; target_bottles = '0;
        model_reset();
        repeat (2) @(posedge clk_1khz);
        #1;
        compare_all();
        switch_clr = 1'b0;

        // Two bottles of three pills
        target_pills = 12'h003; target_bottles = 8'h02;
        sw_samples = 0; done_samples = 0;
        start = 1'b1; tick();
        repeat (3) pill();
        for (int i = 0; i < 20 && state == 3'd2; i++) tick();
        repeat (3) pill();
        check_eq("s1_state",   32'(state), 32'd3);
        check_eq("s1_bottles", 32'(now_bottles), 32'h02);
        check_eq("s1_sw_len",  sw_samples, 32'd8);
        check_eq("s1_pulses",  done_samples, 32'd2);
        ack = 1'b1; tick();
        check_eq("s1_ack", 32'(state), 32'd0);

        // Decimal carry through 009 -> 010
        target_pills = 12'h012; target_bottles = 8'h01;
        start = 1'b1; tick();
        repeat (12) pill();
        check_eq("s2_state", 32'(state), 32'd3);
        check_eq("s2_pills", 32'(now_pills), 32'h012);
        ack = 1'b1; tick();

        // Hopper timeout, recovery, then escalation
        target_pills = 12'h003; target_bottles = 8'h01;
        start = 1'b1; tick();
        repeat (19) tick();
        check_eq("s3_pre_timeout", 32'(state), 32'd1);
        tick();
        check_eq("s3_hopper_err", 32'(state), 32'd4);
        check_eq("s3_cause", 32'(err_cause), 32'd1);
        pill();
        check_eq("s3_recover", 32'(state), 32'd1);
        check_eq("s3_pills", 32'(now_pills), 32'h001);
        for (int i = 0; i < 40 && state != 3'd4; i++) tick();
        check_eq("s3_err_again", 32'(state), 32'd4);
        repeat (11) tick();
        check_eq("s3_err_hold", 32'(state), 32'd4);
        tick();
        check_eq("s3_fatal", 32'(state), 32'd5);
        check_eq("s3_fatal_cause", 32'(err_cause), 32'd1);
        ack = 1'b1; tick();

        // Spill during switching; conveyor fault and recovery
        target_pills = 12'h001; target_bottles = 8'h03; conveyor_ok = 1'b1;
        start = 1'b1; tick();
        pill();
        check_eq("s4_switching", 32'(state), 32'd2);
        pill();
        check_eq("s4_spill", 32'(state), 32'd5);
        check_eq("s4_spill_cause", 32'(err_cause), 32'd3);
        ack = 1'b1; tick();
        start = 1'b1; tick();
        pill();
        conveyor_ok = 1'b0;
        for (int i = 0; i < 20 && state == 3'd2; i++) tick();
        check_eq("s4_conv_err", 32'(state), 32'd4);
        check_eq("s4_conv_cause", 32'(err_cause), 32'd2);
        conveyor_ok = 1'b1; tick();
        check_eq("s4_resume", 32'(state), 32'd1);
        check_eq("s4_resume_pills", 32'(now_pills), 32'h000);
        check_eq("s4_chime", 32'(chime), 32'd1);

        // Emergency stop and zero-target start
        estop = 1'b1; tick();
        check_eq("s5_estop", 32'(state), 32'd5);
        ack = 1'b1; tick();
        check_eq("s5_ack_ignored", 32'(state), 32'd5);
        estop = 1'b0; tick();
        ack = 1'b1; tick();
        check_eq("s5_ack", 32'(state), 32'd0);
        target_pills = 12'h000; target_bottles = 8'h01;
        start = 1'b1; tick();
        check_eq("s5_zero_target", 32'(state), 32'd0);

        // Asynchronous clear while switching
        target_pills = 12'h001; target_bottles = 8'h02;
        start = 1'b1; tick();
        pill();
        check_eq("s6_switching", 32'(state), 32'd2);
        #2 switch_clr = 1'b1;
        #1;
        check_eq("s6_rst_state",   32'(state), 32'd0);
        check_eq("s6_rst_pills",   32'(now_pills), 32'd0);
        check_eq("s6_rst_bottles", 32'(now_bottles), 32'd0);
        check_eq("s6_rst_cause",   32'(err_cause), 32'd0);
        check_eq("s6_rst_done",    32'(bottle_done), 32'd0);
        check_eq("s6_rst_chime",   32'(chime), 32'd0);
        model_reset();
        @(posedge clk_1khz);
        #1 switch_clr = 1'b0;

        // Randomized traffic against the model
        for (int n = 0; n < 1500; n++) begin
            start       = ($urandom % 6) == 0;
            ack         = ($urandom % 8) == 0;
            estop       = ($urandom % 40) == 0;
            conveyor_ok = ($urandom % 6) != 0;
            if (($urandom % 3) == 0) pill_in = ~pill_in;
            if (($urandom % 10) == 0) begin
                tmp = int2bcd($urandom_range(0, 12));
                target_pills = tmp[11:0];
                tmp = int2bcd($urandom_range(0, 3));
                target_bottles = tmp[7:0];
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
